tlb_mmu_assoc: RTL

// - Parametrised fully-associative, ASID-tagged MIPS32-style TLB. Each entry maps an even/odd 4 KB page pair.
// - Sits between the MMU address path and the wishbone address decoder, and is managed by CP0.
// - Registered 1-cycle lookup. Indexed write (WI), random write (WR), read (R) and probe (P) management ops.
// - Random counter honours the wired boundary.

---
 rtl/tlb_mmu_assoc.sv | 318 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/tlb_mmu_assoc.sv
// tlb_mmu_assoc -- fully-associative, ASID-tagged MIPS32-style TLB.
//
// Each entry maps an even/odd pair of 4 KB pages selected by vaddr[12].
// The TLB sits between the MMU address path and the wishbone address
// decoder. CP0 manages it through indexed write, random write, read and
// probe ops. Lookups are registered and complete in one cycle.
//
// Optional feature macro: TLB_PERF_CNT_EN adds saturating 32-bit counters
// perf_lookups (mapped lookups) and perf_refills (refill results).
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   lk_valid/lk_vaddr   lookup request, virtual address
//   lk_write/lk_asid    store flag, current ASID
//   rsp_valid           result valid one cycle after lk_valid
//   rsp_paddr           physical address (0 on any exception)
//   rsp_refill          no matching entry
//   rsp_invalid         matching entry, selected page V=0
//   rsp_mod             store to a valid page with D=0
//   rsp_is_store        registered lk_write
//   perf_lookups/refills  (TLB_PERF_CNT_EN only) event counters
//   cmd_valid/cmd_op    management strobe, op (00 WI, 01 WR, 10 R, 11 P)
//   cmd_index           entry index for WI/R
//   cmd_hi/lo0/lo1      EntryHi / EntryLo0 / EntryLo1 images
//   wired               CP0 Wired lower bound for the random counter
//   cmd_done            pulses one cycle after cmd_valid
//   rd_hi/rd_lo0/rd_lo1 read result
//   probe_idx           probe result {miss, zeros, index}
//   random_idx          current Random value

module tlb_mmu_assoc #(
   parameter int ENTRIES = 16,
   parameter int IDX_W   = 4,
   parameter int ASID_W  = 8,
   parameter int PFN_W   = 20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              lk_valid,
   input  logic [31:0]       lk_vaddr,
   input  logic              lk_write,
   input  logic [ASID_W-1:0] lk_asid,
   output logic              rsp_valid,
   output logic [31:0]       rsp_paddr,
   output logic              rsp_refill,
   output logic              rsp_invalid,
   output logic              rsp_mod,
   output logic              rsp_is_store,
`ifdef TLB_PERF_CNT_EN
   output logic [31:0]       perf_lookups,
   output logic [31:0]       perf_refills,
`endif
   input  logic              cmd_valid,
   input  logic [1:0]        cmd_op,
   input  logic [IDX_W-1:0]  cmd_index,
   input  logic [31:0]       cmd_hi,
   input  logic [31:0]       cmd_lo0,
   input  logic [31:0]       cmd_lo1,
   input  logic [IDX_W-1:0]  wired,
   output logic              cmd_done,
   output logic [31:0]       rd_hi,
   output logic [31:0]       rd_lo0,
   output logic [31:0]       rd_lo1,
   output logic [31:0]       probe_idx,
   output logic [IDX_W-1:0]  random_idx
);

   localparam logic [1:0]       OP_WI    = 2'b00;
   localparam logic [1:0]       OP_WR    = 2'b01;
   localparam logic [1:0]       OP_R     = 2'b10;
   localparam logic [1:0]       OP_P     = 2'b11;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);
   localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

   // Entry storage
   logic [18:0]       vpn2_r [ENTRIES];
   logic [ASID_W-1:0] asid_r [ENTRIES];
   logic [PFN_W-1:0]  pfn0_r [ENTRIES];
   logic [PFN_W-1:0]  pfn1_r [ENTRIES];
   logic [ENTRIES-1:0] g_r;
   logic [ENTRIES-1:0] v0_r;
   logic [ENTRIES-1:0] d0_r;
   logic [ENTRIES-1:0] v1_r;
   logic [ENTRIES-1:0] d1_r;

   logic [IDX_W-1:0]  wired_q_r;

   logic              lk_hit_s;
   logic [IDX_W-1:0]  lk_idx_s;
   logic              mapped_s;
   logic [31:0]       nxt_paddr_s;
   logic              nxt_refill_s;
   logic              nxt_invalid_s;
   logic              nxt_mod_s;
   logic              sel_v_s;
   logic              sel_d_s;
   logic [PFN_W-1:0]  sel_pfn_s;

   logic              pr_hit_s;
   logic [IDX_W-1:0]  pr_idx_s;

   logic              wr_en_s;
   logic [IDX_W-1:0]  wr_idx_s;

   // An entry matches on VPN2 and either the global bit or an equal ASID.
   function automatic logic entry_match(input logic [18:0]       e_vpn2,
                                        input logic [ASID_W-1:0] e_asid,
                                        input logic              e_g,
                                        input logic [18:0]       vpn2,
                                        input logic [ASID_W-1:0] asid);
      return (e_vpn2 == vpn2) && (e_g || (e_asid == asid));
   endfunction

   function automatic logic [31:0] make_paddr(input logic [PFN_W-1:0] pfn,
                                              input logic [11:0]      offs);
      return (32'(pfn) << 12) | {20'h00000, offs};
   endfunction

   // EntryLo image; the cache attribute field is not stored and reads as 0.
   function automatic logic [31:0] pack_lo(input logic [PFN_W-1:0] pfn,
                                           input logic             d,
                                           input logic             v,
                                           input logic             g);
      logic [31:0] lo;
      lo = 32'h00000000;
      lo[6 +: PFN_W] = pfn;
      lo[2] = d;
      lo[1] = v;
      lo[0] = g;
      return lo;
   endfunction

   function automatic logic [31:0] pack_hi(input logic [18:0]       vpn2,
                                           input logic [ASID_W-1:0] asid);
      logic [31:0] hi;
      hi = {vpn2, 13'h0000};
      hi[ASID_W-1:0] = asid;
      return hi;
   endfunction

   // Lookup search; descending scan so the lowest matching index wins.
   always_comb begin
      lk_hit_s = 1'b0;
      lk_idx_s = {IDX_W{1'b0}};
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (entry_match(vpn2_r[i], asid_r[i], g_r[i], lk_vaddr[31:13], lk_asid)) begin
            lk_hit_s = 1'b1;
            lk_idx_s = IDX_W'(i);
         end else begin
            lk_hit_s = lk_hit_s;
         end
      end
   end

   // Translation and exception classification for the current request.
   always_comb begin
      mapped_s      = (lk_vaddr[31:30] != 2'b10);
      nxt_paddr_s   = 32'h00000000;
      nxt_refill_s  = 1'b0;
      nxt_invalid_s = 1'b0;
      nxt_mod_s     = 1'b0;
      sel_v_s       = lk_vaddr[12] ? v1_r[lk_idx_s] : v0_r[lk_idx_s];
      sel_d_s       = lk_vaddr[12] ? d1_r[lk_idx_s] : d0_r[lk_idx_s];
      sel_pfn_s     = lk_vaddr[12] ? pfn1_r[lk_idx_s] : pfn0_r[lk_idx_s];
      if (!mapped_s) begin
         // kseg0/kseg1 bypass the TLB.
         nxt_paddr_s = {3'b000, lk_vaddr[28:0]};
      end else if (!lk_hit_s) begin
         nxt_refill_s = 1'b1;
      end else if (!sel_v_s) begin
         nxt_invalid_s = 1'b1;
      end else if (lk_write && !sel_d_s) begin
         nxt_mod_s = 1'b1;
      end else begin
         nxt_paddr_s = make_paddr(sel_pfn_s, lk_vaddr[11:0]);
      end
   end

   // Probe search against the EntryHi image; lowest index wins.
   always_comb begin
      pr_hit_s = 1'b0;
      pr_idx_s = {IDX_W{1'b0}};
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (entry_match(vpn2_r[i], asid_r[i], g_r[i], cmd_hi[31:13], cmd_hi[ASID_W-1:0])) begin
            pr_hit_s = 1'b1;
            pr_idx_s = IDX_W'(i);
         end else begin
            pr_hit_s = pr_hit_s;
         end
      end
   end

   // Write target: WR uses the Random value present at the command edge.
   always_comb begin
      wr_en_s  = cmd_valid && ((cmd_op == OP_WI) || (cmd_op == OP_WR));
      wr_idx_s = (cmd_op == OP_WR) ? random_idx : cmd_index;
   end

   // Entry array update; reset clears every entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            vpn2_r[i] <= 19'h00000;
            asid_r[i] <= {ASID_W{1'b0}};
            pfn0_r[i] <= {PFN_W{1'b0}};
            pfn1_r[i] <= {PFN_W{1'b0}};
         end
         g_r  <= {ENTRIES{1'b0}};
         v0_r <= {ENTRIES{1'b0}};
         d0_r <= {ENTRIES{1'b0}};
         v1_r <= {ENTRIES{1'b0}};
         d1_r <= {ENTRIES{1'b0}};
      end else if (wr_en_s) begin
         vpn2_r[wr_idx_s] <= cmd_hi[31:13];
         asid_r[wr_idx_s] <= cmd_hi[ASID_W-1:0];
         pfn0_r[wr_idx_s] <= cmd_lo0[6 +: PFN_W];
         pfn1_r[wr_idx_s] <= cmd_lo1[6 +: PFN_W];
         g_r[wr_idx_s]    <= cmd_lo0[0] & cmd_lo1[0];
         d0_r[wr_idx_s]   <= cmd_lo0[2];
         v0_r[wr_idx_s]   <= cmd_lo0[1];
         d1_r[wr_idx_s]   <= cmd_lo1[2];
         v1_r[wr_idx_s]   <= cmd_lo1[1];
      end
   end

   // Registered lookup response; all fields read zero without a request.
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid    <= 1'b0;
         rsp_paddr    <= 32'h00000000;
         rsp_refill   <= 1'b0;
         rsp_invalid  <= 1'b0;
         rsp_mod      <= 1'b0;
         rsp_is_store <= 1'b0;
      end else if (lk_valid) begin
         rsp_valid    <= 1'b1;
         rsp_paddr    <= nxt_paddr_s;
         rsp_refill   <= nxt_refill_s;
         rsp_invalid  <= nxt_invalid_s;
         rsp_mod      <= nxt_mod_s;
         rsp_is_store <= lk_write;
      end else begin
         rsp_valid    <= 1'b0;
         rsp_paddr    <= 32'h00000000;
         rsp_refill   <= 1'b0;
         rsp_invalid  <= 1'b0;
         rsp_mod      <= 1'b0;
         rsp_is_store <= 1'b0;
      end
   end

   // Management results: done strobe, read-back and probe registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_done  <= 1'b0;
         rd_hi     <= 32'h00000000;
         rd_lo0    <= 32'h00000000;
         rd_lo1    <= 32'h00000000;
         probe_idx <= 32'h00000000;
      end else begin
         cmd_done <= cmd_valid;
         if (cmd_valid) begin
            case (cmd_op)
               OP_R: begin
                  rd_hi  <= pack_hi(vpn2_r[cmd_index], asid_r[cmd_index]);
                  rd_lo0 <= pack_lo(pfn0_r[cmd_index], d0_r[cmd_index],
                                    v0_r[cmd_index], g_r[cmd_index]);
                  rd_lo1 <= pack_lo(pfn1_r[cmd_index], d1_r[cmd_index],
                                    v1_r[cmd_index], g_r[cmd_index]);
               end
               OP_P: begin
                  probe_idx <= pr_hit_s ? {{(32 - IDX_W){1'b0}}, pr_idx_s}
                                        : 32'h80000000;
               end
               OP_WI, OP_WR: begin
                  rd_hi <= rd_hi;
               end
               default: begin
                  rd_hi <= rd_hi;
               end
            endcase
         end
      end
   end

   // Random counter: counts down to Wired, then wraps to the top entry.
   // A change of Wired restarts the count from the top.
   always_ff @(posedge clk) begin
      wired_q_r <= wired;
      if (rst) begin
         random_idx <= LAST_IDX;
      end else if ((wired != wired_q_r) || (random_idx <= wired)) begin
         random_idx <= LAST_IDX;
      end else begin
         random_idx <= random_idx - ONE_IDX;
      end
   end

`ifdef TLB_PERF_CNT_EN
   // Saturating event counters for mapped lookups and refills.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_lookups <= 32'h00000000;
         perf_refills <= 32'h00000000;
      end else begin
         if (lk_valid && mapped_s && (perf_lookups != 32'hFFFFFFFF)) begin
            perf_lookups <= perf_lookups + 32'h00000001;
         end
         if (lk_valid && nxt_refill_s && (perf_refills != 32'hFFFFFFFF)) begin
            perf_refills <= perf_refills + 32'h00000001;
         end
      end
   end
`else
   // Performance counters are not built in this configuration.
`endif

endmodule
